spi_reg_bridge: RTL and testbench

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_bridge.sv | 167 ++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that turns one chip-select frame
// (8-bit command + 32 data bits, MSB first) into a single register write
// strobe or a register read returned on MISO.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   spi_cs_n/sclk/mosi  asynchronous SPI inputs from the MCU
//   spi_miso         registered read data to the MCU
//   reg_addr         register byte address {cmd[5:2],2'b00}
//   reg_wdata        write data, updated only when a write frame completes
//   reg_wstrobe      one-clk write pulse
//   reg_rdata        combinational read data for reg_addr
//   frame_abort      one-clk pulse when cs_n rises before the frame completes
module spi_reg_bridge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [5:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wstrobe,
  input  logic [31:0] reg_rdata,
  output logic        frame_abort
);

  localparam int unsigned CNT_W      = 6;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned FRAME_BITS = 40;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_sclk_d;
  logic                   r_armed;

  logic w_cs_n;
  logic w_sclk;
  logic w_mosi;
  logic w_rise;
  logic w_fall;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_cmd;
  logic             r_wr;
  logic             r_cmd_done;
  logic             r_load_rd;
  logic [30:0]      r_wr_shift;
  logic [31:0]      r_rd_shift;

  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_d;
  assign w_fall = ~w_sclk & r_sclk_d;

  // Input synchronisers. r_fill marks when the chain holds real samples so
  // the reset value of the cs_n chain is never mistaken for an observed high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_fill      <= '0;
      r_sclk_d    <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk;
      if (r_fill[SYNC_STAGES-1] && w_cs_n)
        r_armed <= 1'b1;
    end
  end

  // Frame FSM; a cs_n rise is checked before any sclk edge in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_wr        <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_load_rd   <= 1'b0;
      r_wr_shift  <= '0;
      r_rd_shift  <= '0;
      spi_miso    <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wstrobe <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      reg_wstrobe <= 1'b0;
      frame_abort <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_load_rd   <= 1'b0;
      case (r_state)
        IDLE: begin
          spi_miso <= 1'b0;
          r_cnt    <= '0;
          if (r_armed && !w_cs_n)
            r_state <= CMD;
        end
        CMD: begin
          spi_miso <= 1'b0;
          if (w_cs_n) begin
            r_state     <= IDLE;
            frame_abort <= (r_cnt != '0);
          end else if (w_rise) begin
            r_cmd <= {r_cmd[6:0], w_mosi};
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(CMD_BITS - 1)) begin
              r_state    <= DATA;
              r_cmd_done <= 1'b1;
            end
          end
        end
        DATA: begin
          if (w_cs_n) begin
            r_state     <= IDLE;
            frame_abort <= 1'b1;
            spi_miso    <= 1'b0;
          end else begin
            // Address decode one clk after the command, read data one later.
            if (r_cmd_done) begin
              reg_addr  <= {r_cmd[5:2], 2'b00};
              r_wr      <= r_cmd[7];
              r_load_rd <= 1'b1;
            end
            if (r_load_rd)
              r_rd_shift <= reg_rdata;
            if (w_rise) begin
              r_cnt      <= r_cnt + CNT_W'(1);
              r_wr_shift <= {r_wr_shift[29:0], w_mosi};
              if (r_cnt == CNT_W'(FRAME_BITS - 1)) begin
                r_state  <= DONE;
                spi_miso <= 1'b0;
                if (r_wr) begin
                  reg_wdata   <= {r_wr_shift, w_mosi};
                  reg_wstrobe <= 1'b1;
                end
              end
            end else if (w_fall && !r_wr) begin
              spi_miso   <= r_rd_shift[31];
              r_rd_shift <= {r_rd_shift[30:0], 1'b0};
            end
          end
        end
        DONE: begin
          spi_miso <= 1'b0;
          if (w_cs_n)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: SPI master tasks at clk = 8x sclk with
// SYNC_STAGES = 3, a 16-word register model, and pulse monitors.
module tb_spi_reg_bridge;

  logic        clk;
  logic        reset;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wstrobe;
  logic [31:0] reg_rdata;
  logic        frame_abort;

  spi_reg_bridge #(.SYNC_STAGES(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wstrobe (reg_wstrobe),
    .reg_rdata   (reg_rdata),
    .frame_abort (frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register block model: combinational read, write on strobe.
  logic [31:0] regs [16];
  assign reg_rdata = regs[reg_addr[5:2]];
  always @(posedge clk)
    if (reg_wstrobe) regs[reg_addr[5:2]] <= reg_wdata;

  // Pulse monitors, sampled on the inactive edge.
  int          strobe_cnt;
  int          abort_cnt;
  logic        miso_seen;
  logic [5:0]  cap_addr;
  logic [31:0] cap_wdata;
  always @(negedge clk) begin
    if (reg_wstrobe) begin
      strobe_cnt = strobe_cnt + 1;
      cap_addr   = reg_addr;
      cap_wdata  = reg_wdata;
    end
    if (frame_abort) abort_cnt = abort_cnt + 1;
    if (spi_miso) miso_seen = 1'b1;
  end

  int n_tests;
  int n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    strobe_cnt = 0;
    abort_cnt  = 0;
    miso_seen  = 1'b0;
    cap_addr   = '0;
    cap_wdata  = '0;
  endtask

  // Mode-0 master: bits taken MSB first from bits[47]; MISO sampled just
  // before each rising edge. rst_at >= 0 pulses reset after that many rises.
  task automatic spi_xfer(input logic [47:0] bits, input int n, input int rst_at,
                          output logic [47:0] rx);
    rx = '0;
    spi_cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
      end
      spi_mosi = bits[47-i];
      tick(4);
      rx[47-i] = spi_miso;
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
    end
    tick(4);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tick(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [47:0] rx;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    regs[9] = 32'hA5C3_0F01;
    clr_mon();
    tick(5);

    check_eq("rst_miso",   64'(spi_miso),    64'h0);
    check_eq("rst_addr",   64'(reg_addr),    64'h0);
    check_eq("rst_wdata",  64'(reg_wdata),   64'h0);
    check_eq("rst_strobe", 64'(reg_wstrobe), 64'h0);
    check_eq("rst_abort",  64'(frame_abort), 64'h0);
    reset = 1'b0;
    tick(8);

    // Write 0x280 to 0x04
    clr_mon();
    spi_xfer({8'h84, 32'h0000_0280, 8'h00}, 40, -1, rx);
    check_eq("wr_strobes", 64'(strobe_cnt), 64'd1);
    check_eq("wr_addr",    64'(cap_addr),   64'h04);
    check_eq("wr_data",    64'(cap_wdata),  64'h280);
    check_eq("wr_abort",   64'(abort_cnt),  64'd0);
    check_eq("wr_miso0",   64'(miso_seen),  64'd0);
    check_eq("wr_hold",    64'(reg_addr),   64'h04);

    // Read 0x24
    clr_mon();
    spi_xfer({8'h24, 32'h0, 8'h00}, 40, -1, rx);
    check_eq("rd_data",    64'(rx[39:8]),   64'hA5C3_0F01);
    check_eq("rd_cmdmiso", 64'(rx[47:40]),  64'h0);
    check_eq("rd_strobes", 64'(strobe_cnt), 64'd0);
    check_eq("rd_abort",   64'(abort_cnt),  64'd0);
    check_eq("rd_wdata",   64'(reg_wdata),  64'h280);
    check_eq("rd_addr",    64'(reg_addr),   64'h24);
    check_eq("rd_idle0",   64'(spi_miso),   64'h0);

    // Abort after command + 12 data bits
    clr_mon();
    spi_xfer({8'h80, 32'hFFFF_FFFF, 8'h00}, 20, -1, rx);
    check_eq("ab_aborts",  64'(abort_cnt),  64'd1);
    check_eq("ab_strobes", 64'(strobe_cnt), 64'd0);
    check_eq("ab_wdata",   64'(reg_wdata),  64'h280);

    // cs_n rise inside the command byte after 3 bits, then with no bits
    clr_mon();
    spi_xfer({8'h84, 40'h0}, 3, -1, rx);
    check_eq("cmdab_aborts", 64'(abort_cnt), 64'd1);
    clr_mon();
    spi_xfer(48'h0, 0, -1, rx);
    check_eq("empty_aborts", 64'(abort_cnt), 64'd0);

    // Overrun: 48 clocks, trailing byte ignored
    clr_mon();
    spi_xfer({8'h8C, 32'h1234_5678, 8'hFF}, 48, -1, rx);
    check_eq("ov_strobes", 64'(strobe_cnt), 64'd1);
    check_eq("ov_data",    64'(cap_wdata),  64'h1234_5678);
    check_eq("ov_addr",    64'(cap_addr),   64'h0C);
    check_eq("ov_abort",   64'(abort_cnt),  64'd0);
    check_eq("ov_wdata",   64'(reg_wdata),  64'h1234_5678);

    // Back-to-back write then read of 0x20
    clr_mon();
    spi_xfer({8'hA0, 32'h0000_0005, 8'h00}, 40, -1, rx);
    spi_xfer({8'h20, 32'h0, 8'h00}, 40, -1, rx);
    check_eq("b2b_strobes", 64'(strobe_cnt), 64'd1);
    check_eq("b2b_addr",    64'(cap_addr),   64'h20);
    check_eq("b2b_rd",      64'(rx[39:8]),   64'h5);

    // Reset pulsed at bit 20 of a write, then a clean write
    clr_mon();
    spi_xfer({8'h90, 32'hDEAD_BEEF, 8'h00}, 40, 20, rx);
    check_eq("rst_mid_strobes", 64'(strobe_cnt), 64'd0);
    check_eq("rst_mid_aborts",  64'(abort_cnt),  64'd0);
    check_eq("rst_mid_wdata",   64'(reg_wdata),  64'h0);
    check_eq("rst_mid_addr",    64'(reg_addr),   64'h0);
    spi_xfer({8'h94, 32'hCAFE_F00D, 8'h00}, 40, -1, rx);
    check_eq("post_rst_strobes", 64'(strobe_cnt), 64'd1);
    check_eq("post_rst_data",    64'(cap_wdata),  64'hCAFE_F00D);
    check_eq("post_rst_addr",    64'(cap_addr),   64'h14);
    check_eq("post_rst_aborts",  64'(abort_cnt),  64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
